pinball_ball_engine: RTL and testbench

- Downstream consumer of the 640x480 VGA timing generator.
- Takes the pixel coordinates, active flag, pixel strobe and end-of-active-frame tick.
- Once per frame it advances a single pinball ball: gravity, wall bounces, launch and ball-lost sequencing.
- Every pixel it produces registered 12-bit RGB for the playfield: walls plus ball, ready for the DAC/pin stage.

---
 rtl/pinball_ball_engine.sv | 212 +++++++++++++++++++++
 tb/tb_pinball_ball_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pinball_ball_engine.sv
// Pinball ball engine: advances one ball once per frame tick (gravity, wall
// bounces, launch, ball-lost sequencing) and renders walls plus ball as
// registered 12-bit RGB, one pixel strobe behind the incoming coordinates.
// Optional build macro PINBALL_BOUNCE_DAMP_EN: each wall reflection loses one
// unit of speed on the reflected axis (floored at zero); undefined = lossless.
module pinball_ball_engine #(
    parameter int BALL_SIZE   = 8,
    parameter int WALL_W      = 16,
    parameter int BALL_X0     = 600,
    parameter int BALL_Y0     = 400,
    parameter int LAUNCH_VX   = -3,
    parameter int LAUNCH_VY   = -20,
    parameter int GRAVITY     = 1,
    parameter int VMAX        = 24,
    parameter int LOST_FRAMES = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clkenable,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_active,
    input  logic       i_animate,
    input  logic       i_launch,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b,
    output logic [9:0] o_ball_x,
    output logic [8:0] o_ball_y,
    output logic [1:0] o_state,
    output logic       o_lost
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        LOST   = 2'd2
    } state_t;

    localparam logic [9:0]         X0        = 10'(BALL_X0);
    localparam logic [8:0]         Y0        = 9'(BALL_Y0);
    localparam logic signed [5:0]  LVX       = 6'(LAUNCH_VX);
    localparam logic signed [5:0]  LVY       = 6'(LAUNCH_VY);
    localparam logic signed [11:0] GRAV_S    = 12'(GRAVITY);
    localparam logic signed [11:0] VMAX_S    = 12'(VMAX);
    localparam logic signed [11:0] SIZE_S    = 12'(BALL_SIZE);
    localparam logic signed [11:0] WALL_S    = 12'(WALL_W);
    localparam logic signed [11:0] RIGHT_S   = 12'(640 - WALL_W);
    localparam logic signed [11:0] BOTTOM_S  = 12'sd480;
    localparam logic [9:0]         X_PARK_R  = 10'(640 - WALL_W - BALL_SIZE);
    localparam logic [9:0]         Y_PARK_T  = 10'(WALL_W);
    localparam logic [9:0]         WALL_X_LO = 10'(WALL_W);
    localparam logic [9:0]         WALL_X_HI = 10'(640 - WALL_W);
    localparam logic [8:0]         WALL_Y    = 9'(WALL_W);
    localparam logic [10:0]        SIZE_X    = 11'(BALL_SIZE);
    localparam logic [9:0]         SIZE_Y    = 10'(BALL_SIZE);
    localparam logic [7:0]         LOST_LAST = 8'(LOST_FRAMES - 1);

    // Gravity-updated vy clamped to +VMAX (and to the 6-bit floor).
    function automatic logic signed [5:0] sat_vy(input logic signed [11:0] v);
        if (v > VMAX_S)
            return VMAX_S[5:0];
        else if (v < -12'sd32)
            return -6'sd32;
        else
            return v[5:0];
    endfunction

    // Wall reflection: negate with -32 saturating to +31, optional damping.
    function automatic logic signed [5:0] reflect(input logic signed [5:0] v);
        logic signed [6:0] r;
        r = -$signed({v[5], v});
        if (r > 7'sd31)
            r = 7'sd31;
`ifdef PINBALL_BOUNCE_DAMP_EN
        if (r > 7'sd0)
            r = r - 7'sd1;
        else if (r < 7'sd0)
            r = r + 7'sd1;
`endif
        return r[5:0];
    endfunction

    state_t            state;
    logic [9:0]        ball_x;
    logic [8:0]        ball_y;
    logic signed [5:0] vx;
    logic signed [5:0] vy;
    logic [7:0]        lost_cnt;
    logic [11:0]       rgb_p1;

    logic              tick;
    logic signed [5:0] vy_g;
    logic signed [11:0] nx;
    logic signed [11:0] ny;
    logic              hit_left;
    logic              hit_right;
    logic              hit_top;
    logic              hit_bottom;
    logic              in_ball;
    logic              wall_px;

    assign tick = i_animate & i_clkenable;

    // Candidate motion for the next frame in 12-bit signed arithmetic.
    always_comb begin
        vy_g       = sat_vy($signed({{6{vy[5]}}, vy}) + GRAV_S);
        nx         = $signed({2'b00, ball_x}) + $signed({{6{vx[5]}}, vx});
        ny         = $signed({3'b000, ball_y}) + $signed({{6{vy_g[5]}}, vy_g});
        hit_left   = nx < WALL_S;
        hit_right  = (nx + SIZE_S) > RIGHT_S;
        hit_top    = ny < WALL_S;
        hit_bottom = (ny + SIZE_S) >= BOTTOM_S;
    end

    // Ball FSM: launch, per-frame motion with bounces, lost countdown.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            ball_x   <= X0;
            ball_y   <= Y0;
            vx       <= '0;
            vy       <= '0;
            lost_cnt <= '0;
            o_lost   <= 1'b0;
        end else begin
            o_lost <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        ball_x <= X0;
                        ball_y <= Y0;
                        if (i_launch) begin
                            vx    <= LVX;
                            vy    <= LVY;
                            state <= MOVING;
                        end
                    end
                    MOVING: begin
                        if (hit_bottom) begin
                            state  <= LOST;
                            o_lost <= 1'b1;
                            vx     <= '0;
                            vy     <= '0;
                        end else begin
                            if (hit_left) begin
                                ball_x <= WALL_X_LO;
                                vx     <= reflect(vx);
                            end else if (hit_right) begin
                                ball_x <= X_PARK_R;
                                vx     <= reflect(vx);
                            end else begin
                                ball_x <= nx[9:0];
                            end
                            if (hit_top) begin
                                ball_y <= Y_PARK_T[8:0];
                                vy     <= reflect(vy_g);
                            end else begin
                                ball_y <= ny[8:0];
                                vy     <= vy_g;
                            end
                        end
                    end
                    LOST: begin
                        if (lost_cnt == LOST_LAST) begin
                            lost_cnt <= '0;
                            ball_x   <= X0;
                            ball_y   <= Y0;
                            state    <= IDLE;
                        end else begin
                            lost_cnt <= lost_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Pixel classification against the current ball square and the walls.
    always_comb begin
        in_ball = ({1'b0, i_x} >= {1'b0, ball_x}) &&
                  ({1'b0, i_x} <  ({1'b0, ball_x} + SIZE_X)) &&
                  ({1'b0, i_y} >= {1'b0, ball_y}) &&
                  ({1'b0, i_y} <  ({1'b0, ball_y} + SIZE_Y));
        wall_px = (i_x < WALL_X_LO) || (i_x >= WALL_X_HI) || (i_y < WALL_Y);
    end

    // Registered colour, advanced once per pixel strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rgb_p1 <= '0;
        end else if (i_clkenable) begin
            if (!i_active)
                rgb_p1 <= 12'h000;
            else if ((state != LOST) && in_ball)
                rgb_p1 <= 12'hFFF;
            else if (wall_px)
                rgb_p1 <= 12'h00F;
            else
                rgb_p1 <= 12'h000;
        end
    end

    assign o_r      = rgb_p1[11:8];
    assign o_g      = rgb_p1[7:4];
    assign o_b      = rgb_p1[3:0];
    assign o_ball_x = ball_x;
    assign o_ball_y = ball_y;
    assign o_state  = state;

endmodule

// File: tb/tb_pinball_ball_engine.sv
// Testbench for pinball_ball_engine: reference model feeds a scoreboard queue
// of expected state/position and pixel colours, compared after each edge.
module tb_pinball_ball_engine;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_clkenable = 1'b0;
    logic [9:0] i_x = '0;
    logic [8:0] i_y = '0;
    logic       i_active = 1'b0;
    logic       i_animate = 1'b0;
    logic       i_launch = 1'b0;
    logic [3:0] o_r, o_g, o_b;
    logic [9:0] o_ball_x;
    logic [8:0] o_ball_y;
    logic [1:0] o_state;
    logic       o_lost;

    pinball_ball_engine dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clkenable(i_clkenable),
        .i_x(i_x), .i_y(i_y), .i_active(i_active), .i_animate(i_animate),
        .i_launch(i_launch), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_ball_x(o_ball_x), .o_ball_y(o_ball_y), .o_state(o_state),
        .o_lost(o_lost)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int st;
        int x;
        int y;
        int lost;
    } exp_t;

    exp_t sb_tick[$];
    int   sb_pix[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int m_state, m_x, m_y, m_vx, m_vy, m_cnt, m_lost;

`ifdef PINBALL_BOUNCE_DAMP_EN
    localparam bit DAMP = 1'b1;
`else
    localparam bit DAMP = 1'b0;
`endif

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int refl(input int v);
        int r;
        r = -v;
        if (r > 31) r = 31;
        if (DAMP) begin
            if (r > 0) r = r - 1;
            else if (r < 0) r = r + 1;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 600; m_y = 400; m_vx = 0; m_vy = 0; m_cnt = 0; m_lost = 0;
    endtask

    task automatic model_tick(input bit launch);
        int vyn, nx, ny;
        m_lost = 0;
        case (m_state)
            0: begin
                m_x = 600; m_y = 400;
                if (launch) begin m_vx = -3; m_vy = -20; m_state = 1; end
            end
            1: begin
                vyn = m_vy + 1;
                if (vyn > 24) vyn = 24;
                nx = m_x + m_vx;
                ny = m_y + vyn;
                if (ny + 8 >= 480) begin
                    m_state = 2; m_lost = 1; m_vx = 0; m_vy = 0;
                end else begin
                    if (nx < 16) begin m_x = 16; m_vx = refl(m_vx); end
                    else if (nx + 8 > 624) begin m_x = 616; m_vx = refl(m_vx); end
                    else m_x = nx;
                    if (ny < 16) begin m_y = 16; m_vy = refl(vyn); end
                    else begin m_y = ny; m_vy = vyn; end
                end
            end
            default: begin
                if (m_cnt == 59) begin m_cnt = 0; m_x = 600; m_y = 400; m_state = 0; end
                else m_cnt++;
            end
        endcase
    endtask

    function automatic int pix_exp(input int px, input int py, input bit act);
        if (!act) return 'h000;
        if (m_state != 2 && px >= m_x && px < m_x + 8 && py >= m_y && py < m_y + 8)
            return 'hFFF;
        if (px < 16 || px >= 624 || py < 16) return 'h00F;
        return 'h000;
    endfunction

    task automatic do_tick(input bit launch);
        exp_t e;
        @(negedge i_clk);
        i_animate = 1'b1; i_clkenable = 1'b1; i_launch = launch; i_active = 1'b0;
        model_tick(launch);
        e.st = m_state; e.x = m_x; e.y = m_y; e.lost = m_lost;
        sb_tick.push_back(e);
        @(negedge i_clk);
        i_animate = 1'b0; i_clkenable = 1'b0;
        e = sb_tick.pop_front();
        check_eq("state", int'(o_state), e.st);
        check_eq("ball_x", int'(o_ball_x), e.x);
        check_eq("ball_y", int'(o_ball_y), e.y);
        check_eq("lost", int'(o_lost), e.lost);
        if (e.lost == 1) begin
            @(negedge i_clk);
            check_eq("lost_one_cycle", int'(o_lost), 0);
        end
    endtask

    task automatic pix(input string tag, input int px, input int py, input bit act);
        @(negedge i_clk);
        i_x = 10'(px); i_y = 9'(py); i_active = act; i_clkenable = 1'b1; i_animate = 1'b0;
        sb_pix.push_back(pix_exp(px, py, act));
        @(negedge i_clk);
        i_clkenable = 1'b0;
        check_eq(tag, int'({o_r, o_g, o_b}), sb_pix.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int n;
        model_reset();
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check_eq("rst_state", int'(o_state), 0);
        check_eq("rst_x", int'(o_ball_x), 600);
        check_eq("rst_y", int'(o_ball_y), 400);
        check_eq("rst_rgb", int'({o_r, o_g, o_b}), 0);
        check_eq("rst_lost", int'(o_lost), 0);

        repeat (3) do_tick(1'b0);

        // pixel path while parked
        pix("ball_px", 604, 404, 1'b1);
        check_eq("ball_px_const", int'({o_r, o_g, o_b}), 'hFFF);
        pix("ball_edge_lo", 607, 407, 1'b1);
        pix("ball_right_out", 608, 404, 1'b1);
        pix("ball_left_out", 599, 404, 1'b1);
        pix("wall_left", 0, 100, 1'b1);
        check_eq("wall_left_const", int'({o_r, o_g, o_b}), 'h00F);
        pix("wall_right", 639, 100, 1'b1);
        pix("wall_right_edge", 624, 100, 1'b1);
        pix("wall_top", 320, 5, 1'b1);
        pix("field", 320, 240, 1'b1);
        pix("inactive_wall", 0, 100, 1'b0);
        pix("inactive_ball", 604, 404, 1'b0);
        pix("hold_src", 604, 404, 1'b1);
        @(negedge i_clk);
        i_x = 10'd320; i_y = 9'd240; i_active = 1'b1; i_clkenable = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("rgb_hold", int'({o_r, o_g, o_b}), 'hFFF);

        // launch and first frames of flight
        do_tick(1'b1);
        check_eq("launch_pos", int'({o_ball_x, o_ball_y}), int'({10'd600, 9'd400}));
        do_tick(1'b0);
        check_eq("fly1", int'({o_ball_x, o_ball_y}), int'({10'd597, 9'd381}));
        do_tick(1'b0);
        check_eq("fly2", int'({o_ball_x, o_ball_y}), int'({10'd594, 9'd363}));

        // i_animate held several cycles with a single qualified tick
        @(negedge i_clk);
        i_animate = 1'b1; i_clkenable = 1'b1; i_launch = 1'b0; i_active = 1'b0;
        model_tick(1'b0);
        e.st = m_state; e.x = m_x; e.y = m_y; e.lost = m_lost;
        sb_tick.push_back(e);
        @(negedge i_clk);
        i_clkenable = 1'b0;
        repeat (3) @(negedge i_clk);
        i_animate = 1'b0;
        e = sb_tick.pop_front();
        check_eq("multi_anim_x", int'(o_ball_x), e.x);
        check_eq("multi_anim_y", int'(o_ball_y), e.y);

        // left wall bounce
        @(negedge i_clk);
        force dut.ball_x = 10'd18;
        force dut.vx = -6'sd5;
        #1;
        release dut.ball_x;
        release dut.vx;
        m_x = 18; m_vx = -5;
        do_tick(1'b0);
        check_eq("left_wall_x", int'(o_ball_x), 16);
        do_tick(1'b0);
        check_eq("left_bounce_vx", int'(o_ball_x), DAMP ? 20 : 21);

        // corner hit: right and top walls in the same frame
        @(negedge i_clk);
        force dut.ball_x = 10'd614;
        force dut.vx = 6'sd5;
        force dut.ball_y = 9'd20;
        force dut.vy = -6'sd10;
        #1;
        release dut.ball_x;
        release dut.vx;
        release dut.ball_y;
        release dut.vy;
        m_x = 614; m_vx = 5; m_y = 20; m_vy = -10;
        do_tick(1'b0);
        check_eq("corner_pos", int'({o_ball_x, o_ball_y}), int'({10'd616, 9'd16}));
        do_tick(1'b0);
        check_eq("corner_next_x", int'(o_ball_x), DAMP ? 612 : 611);
        check_eq("corner_next_y", int'(o_ball_y), DAMP ? 25 : 26);

        // fall until the ball is lost
        n = 0;
        while (m_state == 1 && n < 100) begin
            do_tick(1'b0);
            n++;
        end
        check_eq("reached_lost", int'(o_state), 2);
        pix("lost_ball_hidden", m_x + 2, m_y + 2, 1'b1);

        // lost countdown with launch held
        for (int i = 0; i < 60; i++) do_tick(1'b1);
        check_eq("reparked_state", int'(o_state), 0);
        check_eq("reparked_pos", int'({o_ball_x, o_ball_y}), int'({10'd600, 9'd400}));

        // relaunch, then reset on the same cycle as a tick
        do_tick(1'b1);
        do_tick(1'b0);
        pix("pre_reset_wall", 0, 100, 1'b1);
        @(negedge i_clk);
        i_rst = 1'b1; i_animate = 1'b1; i_clkenable = 1'b1; i_launch = 1'b1;
        i_active = 1'b1; i_x = 10'd0; i_y = 9'd100;
        @(negedge i_clk);
        i_rst = 1'b0; i_animate = 1'b0; i_clkenable = 1'b0; i_launch = 1'b0;
        model_reset();
        check_eq("mid_rst_state", int'(o_state), 0);
        check_eq("mid_rst_pos", int'({o_ball_x, o_ball_y}), int'({10'd600, 9'd400}));
        check_eq("mid_rst_rgb", int'({o_r, o_g, o_b}), 0);
        check_eq("mid_rst_lost", int'(o_lost), 0);
        do_tick(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
